// File: rtl/pid_pkg.sv
// Shared defaults, channel indices and FSM state type for the PID error calculator.
package pid_pkg;

   localparam int DEF_W   = 24;
   localparam int DEF_NCH = 3;
   localparam int DEF_I_W = 32;

   localparam int CH_PITCH = 0;
   localparam int CH_ROLL  = 1;
   localparam int CH_YAW   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } pid_state_e;

endpackage

// File: rtl/pid_sat.sv
// Signed saturator: narrows an IN_W two's-complement value to OUT_W bits,
// clipping to [MIN_VAL, MAX_VAL] (full OUT_W range unless overridden).
module pid_sat #(
   parameter int     IN_W    = 25,
   parameter int     OUT_W   = 24,
   parameter longint MAX_VAL = (64'sd1 <<< (OUT_W - 1)) - 64'sd1,
   parameter longint MIN_VAL = -(64'sd1 <<< (OUT_W - 1))
) (
   input  logic [IN_W-1:0]  din,
   output logic [OUT_W-1:0] dout
);

   localparam logic signed [IN_W-1:0] MAX_IN = IN_W'(MAX_VAL);
   localparam logic signed [IN_W-1:0] MIN_IN = IN_W'(MIN_VAL);

   // Clip against the limits; in-range values pass through truncated
   always_comb begin
      dout = din[OUT_W-1:0];
      if ($signed(din) > MAX_IN) begin
         dout = MAX_IN[OUT_W-1:0];
      end else if ($signed(din) < MIN_IN) begin
         dout = MIN_IN[OUT_W-1:0];
      end else begin
         dout = din[OUT_W-1:0];
      end
   end

endmodule

// File: rtl/pid_error_calc.sv
// Time-multiplexed P/I/D error calculator: one shared signed datapath walks
// NCH channels, one per clock, after each accepted start.
module pid_error_calc
   import pid_pkg::*;
#(
   parameter int     W     = DEF_W,
   parameter int     NCH   = DEF_NCH,
   parameter int     I_W   = DEF_I_W,
   parameter longint I_LIM = (64'sd1 <<< 30) - 64'sd1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               freeze_i,
   input  logic               clear_i,
   input  logic [NCH*W-1:0]   tgt_flat,
   input  logic [NCH*W-1:0]   cur_flat,
   output logic               busy,
   output logic               done,
   output logic [NCH*W-1:0]   err_flat,
   output logic [NCH*I_W-1:0] i_err_flat,
   output logic [NCH*W-1:0]   d_err_flat,
   output logic [NCH-1:0]     i_sat
);

   localparam int              CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CH_W-1:0] CH_LAST = CH_W'(NCH - 1);

   pid_state_e      state_r, state_nx_s;
   logic [CH_W-1:0] ch_r;
   logic            busy_r, done_r;

   logic [W-1:0]    tgt_snap_r [NCH];
   logic [W-1:0]    cur_snap_r [NCH];
   logic [W-1:0]    err_r      [NCH];
   logic [W-1:0]    d_r        [NCH];
   logic [W-1:0]    e_prev_r   [NCH];
   logic [I_W-1:0]  i_r        [NCH];
   logic [NCH-1:0]  i_sat_r, first_r;

   logic [W-1:0]    tgt_s, cur_s, e_s, e_prev_s, d_raw_s, d_s;
   logic [W:0]      e_diff_s, d_diff_s;
   logic [I_W-1:0]  i_cur_s, i_next_s;
   logic [I_W:0]    i_sum_s;
   logic            i_clamp_s;

   // Operand select for the active channel; derivative forced to zero on a first sample
   always_comb begin
      tgt_s    = tgt_snap_r[ch_r];
      cur_s    = cur_snap_r[ch_r];
      e_prev_s = e_prev_r[ch_r];
      i_cur_s  = i_r[ch_r];
      if (first_r[ch_r]) begin
         d_s = {W{1'b0}};
      end else begin
         d_s = d_raw_s;
      end
   end

   assign e_diff_s  = {tgt_s[W-1], tgt_s} - {cur_s[W-1], cur_s};
   assign d_diff_s  = {e_s[W-1], e_s} - {e_prev_s[W-1], e_prev_s};
   assign i_sum_s   = {i_cur_s[I_W-1], i_cur_s} + {{(I_W + 1 - W){e_s[W-1]}}, e_s};
   assign i_clamp_s = (i_sum_s != {i_next_s[I_W-1], i_next_s});

   pid_sat #(.IN_W(W + 1), .OUT_W(W)) u_sat_e (.din(e_diff_s), .dout(e_s));
   pid_sat #(.IN_W(W + 1), .OUT_W(W)) u_sat_d (.din(d_diff_s), .dout(d_raw_s));
   pid_sat #(
      .IN_W(I_W + 1), .OUT_W(I_W), .MAX_VAL(I_LIM), .MIN_VAL(-I_LIM)
   ) u_sat_i (.din(i_sum_s), .dout(i_next_s));

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = RUN;
            end else begin
               state_nx_s = IDLE;
            end
         end
         RUN: begin
            if (ch_r == CH_LAST) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = RUN;
            end
         end
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // State, channel counter and handshake registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         ch_r    <= {CH_W{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         busy_r  <= (state_nx_s != IDLE);
         done_r  <= (state_r == DONE);
         if (state_r == RUN) begin
            ch_r <= ch_r + CH_W'(1'b1);
         end else begin
            ch_r <= {CH_W{1'b0}};
         end
      end
   end

   // Snapshot, per-channel results and history; clear is applied last so it wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NCH; c++) begin
            tgt_snap_r[c] <= {W{1'b0}};
            cur_snap_r[c] <= {W{1'b0}};
            err_r[c]      <= {W{1'b0}};
            d_r[c]        <= {W{1'b0}};
            e_prev_r[c]   <= {W{1'b0}};
            i_r[c]        <= {I_W{1'b0}};
         end
         i_sat_r <= {NCH{1'b0}};
         first_r <= {NCH{1'b1}};
      end else begin
         if ((state_r == IDLE) && start) begin
            for (int c = 0; c < NCH; c++) begin
               tgt_snap_r[c] <= tgt_flat[c*W +: W];
               cur_snap_r[c] <= cur_flat[c*W +: W];
            end
         end
         if (state_r == RUN) begin
            err_r[ch_r]    <= e_s;
            d_r[ch_r]      <= d_s;
            e_prev_r[ch_r] <= e_s;
            first_r[ch_r]  <= 1'b0;
            if (!freeze_i) begin
               i_r[ch_r]     <= i_next_s;
               i_sat_r[ch_r] <= i_clamp_s;
            end
         end
         if (clear_i) begin
            for (int c = 0; c < NCH; c++) begin
               i_r[c]      <= {I_W{1'b0}};
               e_prev_r[c] <= {W{1'b0}};
            end
            i_sat_r <= {NCH{1'b0}};
            first_r <= {NCH{1'b1}};
         end
      end
   end

   assign busy  = busy_r;
   assign done  = done_r;
   assign i_sat = i_sat_r;

   for (genvar g = 0; g < NCH; g++) begin : g_out
      assign err_flat[g*W +: W]     = err_r[g];
      assign d_err_flat[g*W +: W]   = d_r[g];
      assign i_err_flat[g*I_W +: I_W] = i_r[g];
   end

endmodule

// File: tb/tb_pid_error_calc.sv
// Self-checking bench for pid_error_calc: directed cases plus randomized updates
// checked against a per-channel arithmetic model.
module tb_pid_error_calc;

   localparam int     W   = 24;
   localparam int     NCH = 3;
   localparam int     I_W = 32;
   localparam longint LIM = 1000;
   localparam longint EMAX = (64'sd1 <<< (W - 1)) - 64'sd1;
   localparam longint EMIN = -(64'sd1 <<< (W - 1));

   logic               clk = 1'b0;
   logic               rst_n, start, freeze_i, clear_i;
   logic [NCH*W-1:0]   tgt_flat, cur_flat;
   logic               busy, done;
   logic [NCH*W-1:0]   err_flat, d_err_flat;
   logic [NCH*I_W-1:0] i_err_flat;
   logic [NCH-1:0]     i_sat;

   int total = 0;
   int bad   = 0;

   longint m_err [NCH];
   longint m_d   [NCH];
   longint m_i   [NCH];
   longint m_prev[NCH];
   bit     m_sat [NCH];
   bit     m_first[NCH];

   pid_error_calc #(.W(W), .NCH(NCH), .I_W(I_W), .I_LIM(LIM)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .freeze_i(freeze_i), .clear_i(clear_i),
      .tgt_flat(tgt_flat), .cur_flat(cur_flat), .busy(busy), .done(done),
      .err_flat(err_flat), .i_err_flat(i_err_flat), .d_err_flat(d_err_flat), .i_sat(i_sat)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint clip(input longint v, input longint lo, input longint hi);
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   function automatic longint ch_val(input logic [NCH*W-1:0] f, input int c);
      return longint'($signed(f[c*W +: W]));
   endfunction

   function automatic longint i_val(input int c);
      return longint'($signed(i_err_flat[c*I_W +: I_W]));
   endfunction

   function automatic logic [NCH*W-1:0] pack3(input longint a, input longint b, input longint c);
      logic [NCH*W-1:0] p;
      p[0 +: W]   = a[W-1:0];
      p[W +: W]   = b[W-1:0];
      p[2*W +: W] = c[W-1:0];
      return p;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_err[c] = 0; m_d[c] = 0; m_i[c] = 0; m_prev[c] = 0;
         m_sat[c] = 1'b0; m_first[c] = 1'b1;
      end
   endtask

   task automatic model_step(input int c, input longint t, input longint u,
                             input bit frz, input bit clr);
      longint e, sum;
      e   = clip(t - u, EMIN, EMAX);
      sum = m_i[c] + e;
      m_d[c]   = m_first[c] ? 0 : clip(e - m_prev[c], EMIN, EMAX);
      m_err[c] = e;
      if (!frz) begin
         m_i[c]   = clip(sum, -LIM, LIM);
         m_sat[c] = (sum > LIM) || (sum < -LIM);
      end
      m_prev[c]  = e;
      m_first[c] = 1'b0;
      if (clr) begin
         for (int k = 0; k < NCH; k++) begin
            m_i[k] = 0; m_sat[k] = 1'b0; m_prev[k] = 0; m_first[k] = 1'b1;
         end
      end
   endtask

   task automatic check_all(input string where);
      for (int c = 0; c < NCH; c++) begin
         check_eq($sformatf("%s err%0d", where, c), ch_val(err_flat, c), m_err[c]);
         check_eq($sformatf("%s d%0d", where, c), ch_val(d_err_flat, c), m_d[c]);
         check_eq($sformatf("%s i%0d", where, c), i_val(c), m_i[c]);
         check_eq($sformatf("%s isat%0d", where, c), longint'(i_sat[c]), longint'(m_sat[c]));
      end
   endtask

   task automatic run_update(input logic [NCH*W-1:0] tg, input logic [NCH*W-1:0] cu,
                             input bit frz, input int clr_at);
      @(negedge clk);
      check_eq("idle done", longint'(done), 0);
      check_eq("idle busy", longint'(busy), 0);
      tgt_flat = tg; cur_flat = cu; start = 1'b1; freeze_i = frz; clear_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      tgt_flat = (NCH*W)'({$urandom(), $urandom(), $urandom()});
      cur_flat = (NCH*W)'({$urandom(), $urandom(), $urandom()});
      for (int c = 0; c < NCH; c++) begin
         clear_i = (clr_at == c);
         @(posedge clk);
         model_step(c, ch_val(tg, c), ch_val(cu, c), frz, clr_at == c);
         @(negedge clk);
         clear_i = 1'b0;
         check_all($sformatf("ch%0d", c));
         check_eq("run busy", longint'(busy), 1);
         check_eq("run done", longint'(done), 0);
      end
      @(negedge clk);
      check_eq("done pulse", longint'(done), 1);
      check_eq("done busy", longint'(busy), 0);
      check_all("hold");
      freeze_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int     cnt, first_idx, last_idx;
      longint hold_i[NCH];
      longint a, b;

      rst_n = 1'b0; start = 1'b0; freeze_i = 1'b0; clear_i = 1'b0;
      tgt_flat = '0; cur_flat = '0;
      model_reset();
      #12;
      check_all("reset");
      check_eq("reset busy", longint'(busy), 0);
      check_eq("reset done", longint'(done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_update(pack3(100, -50, 0), pack3(40, -50, 10), 1'b0, -1);
      check_eq("tp1 err0", ch_val(err_flat, 0), 60);
      check_eq("tp1 err2", ch_val(err_flat, 2), -10);
      check_eq("tp1 i2", i_val(2), -10);
      check_eq("tp1 d0", ch_val(d_err_flat, 0), 0);
      run_update(pack3(100, -50, 0), pack3(40, -50, 10), 1'b0, -1);
      check_eq("tp2 i0", i_val(0), 120);
      run_update(pack3(100, -50, 0), pack3(0, -50, 10), 1'b0, -1);
      check_eq("tp2 err0", ch_val(err_flat, 0), 100);
      check_eq("tp2 d0", ch_val(d_err_flat, 0), 40);
      check_eq("tp2 i0b", i_val(0), 220);

      run_update(pack3(EMAX, 0, 0), pack3(EMIN, 0, 0), 1'b0, -1);
      check_eq("sat pos", ch_val(err_flat, 0), EMAX);
      run_update(pack3(EMIN, 0, 0), pack3(EMAX, 0, 0), 1'b0, -1);
      check_eq("sat neg", ch_val(err_flat, 0), EMIN);

      run_update(pack3(0, 0, 0), pack3(0, 0, 0), 1'b0, NCH - 1);
      run_update(pack3(600, 0, 0), pack3(0, 0, 0), 1'b0, -1);
      check_eq("lim i0 a", i_val(0), 600);
      check_eq("lim sat a", longint'(i_sat[0]), 0);
      run_update(pack3(600, 0, 0), pack3(0, 0, 0), 1'b0, -1);
      check_eq("lim i0 b", i_val(0), 1000);
      check_eq("lim sat b", longint'(i_sat[0]), 1);
      run_update(pack3(600, 0, 0), pack3(0, 0, 0), 1'b0, -1);
      check_eq("lim i0 c", i_val(0), 1000);
      check_eq("lim sat c", longint'(i_sat[0]), 1);

      for (int c = 0; c < NCH; c++) hold_i[c] = i_val(c);
      run_update(pack3(-300, 77, 5), pack3(12, -40, 9), 1'b1, -1);
      for (int c = 0; c < NCH; c++) check_eq($sformatf("frz i%0d", c), i_val(c), hold_i[c]);
      check_eq("frz err1", ch_val(err_flat, 1), 117);

      run_update(pack3(250, -80, 33), pack3(10, 20, 33), 1'b0, 1);
      check_eq("clr i0", i_val(0), 0);
      check_eq("clr i1", i_val(1), 0);
      run_update(pack3(90, 60, 33), pack3(-10, 0, 33), 1'b0, -1);
      for (int c = 0; c < NCH; c++) check_eq($sformatf("clr d%0d", c), ch_val(d_err_flat, c), 0);

      for (int n = 0; n < 30; n++) begin
         logic [NCH*W-1:0] tg, cu;
         for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 3) == 0) begin
               a = longint'($signed(W'($urandom())));
               b = longint'($signed(W'($urandom())));
            end else begin
               a = longint'($urandom_range(0, 4000)) - 2000;
               b = longint'($urandom_range(0, 4000)) - 2000;
            end
            tg[c*W +: W] = a[W-1:0];
            cu[c*W +: W] = b[W-1:0];
         end
         run_update(tg, cu, $urandom_range(0, 3) == 0, int'($urandom_range(0, 9)));
      end

      start = 1'b1;
      tgt_flat = pack3(5, 6, 7); cur_flat = pack3(1, 2, 3);
      cnt = 0; first_idx = 0; last_idx = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk);
         @(negedge clk);
         if (done) begin
            cnt++;
            if (first_idx == 0) first_idx = k;
            last_idx = k;
         end
      end
      start = 1'b0;
      check_eq("held count", longint'(cnt), 4);
      check_eq("held first", longint'(first_idx), NCH + 2);
      check_eq("held last", longint'(last_idx), 4 * (NCH + 2));

      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst mid");
      check_eq("rst busy", longint'(busy), 0);
      check_eq("rst done", longint'(done), 0);
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (done) cnt++;
      end
      check_eq("rst no done", longint'(cnt), 0);
      rst_n = 1'b1;
      run_update(pack3(-7, 1234, 0), pack3(3, 0, -9), 1'b0, -1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
